// File: rtl/mna_pkg.sv
// -----------------------------------------------------------------------------
// mna_pkg
// Shared types and helpers for the MNA stamp assembler.
//   state_t   : stamp-processing FSM states
//   sat_res_t : result of a saturating add (value plus clamp indicator)
//   sat_add() : add two W-bit two's-complement values, clamped to W bits
//   is_gnd()  : node index at or beyond the matrix order denotes ground
// -----------------------------------------------------------------------------
package mna_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD_A,
        ST_ADD_B,
        ST_OFFDIAG,
        ST_COMMIT
    } state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_res_t;

    // Operands are sign-extended W-bit values (W well below 63), so the 64-bit
    // sum is exact and the clamp below is the only place range is enforced.
    function automatic sat_res_t sat_add(input logic signed [63:0] x,
                                         input logic signed [63:0] y,
                                         input int                 w);
        sat_res_t           res;
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v     = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (w - 1));
        sum       = x + y;
        res.value = sum;
        res.sat   = 1'b0;
        if (sum > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (sum < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

    function automatic logic is_gnd(input int node, input int size);
        return node >= size;
    endfunction

endpackage

// File: rtl/mna_stamper.sv
// -----------------------------------------------------------------------------
// mna_stamper
// Accumulates two-terminal element stamps (conductance g between nodes a and b,
// Norton current i into a / out of b) into working nodal matrix/vector
// registers, and on the last stamp of a frame commits them to held outputs.
// Ports:
//   clk, I_RST                     clock, synchronous active-high reset
//   stamp_valid / stamp_ready      stamp handshake (one stamp per 4 cycles max)
//   stamp_first / stamp_last       frame delimiters
//   stamp_node_a / stamp_node_b    node indices, >= SIZE means ground
//   stamp_g / stamp_i              signed fixed-point conductance / current
//   A, b                           committed matrix and vector
//   matrix_valid                   one-cycle pulse when A/b update
//   matrix_saturated               an add clamped in the committed frame
//   diag_zero                      some committed diagonal entry is zero
// -----------------------------------------------------------------------------
module mna_stamper
    import mna_pkg::*;
#(
    parameter  int SIZE      = 3,
    parameter  int PRECISION = 16,
    parameter  int POINT     = 8,
    localparam int W         = PRECISION + POINT,
    localparam int NW        = $clog2(SIZE + 1)
) (
    input  logic                clk,
    input  logic                I_RST,
    input  logic                stamp_valid,
    output logic                stamp_ready,
    input  logic                stamp_first,
    input  logic                stamp_last,
    input  logic [NW-1:0]       stamp_node_a,
    input  logic [NW-1:0]       stamp_node_b,
    input  logic signed [W-1:0] stamp_g,
    input  logic signed [W-1:0] stamp_i,
    output logic signed [W-1:0] A [SIZE][SIZE],
    output logic signed [W-1:0] b [SIZE],
    output logic                matrix_valid,
    output logic                matrix_saturated,
    output logic                diag_zero
);

    state_t              r_state;
    logic [NW-1:0]       r_node_a;
    logic [NW-1:0]       r_node_b;
    logic signed [W-1:0] r_g;
    logic signed [W-1:0] r_i;
    logic                r_last;
    logic                r_sticky;
    logic signed [W-1:0] r_work_a [SIZE][SIZE];
    logic signed [W-1:0] r_work_b [SIZE];

    logic          w_a_gnd;
    logic          w_b_gnd;
    logic          w_same;
    logic [NW-1:0] w_ia;
    logic [NW-1:0] w_ib;
    logic          w_diag_zero;
    sat_res_t      w_aa;
    sat_res_t      w_ba;
    sat_res_t      w_bb;
    sat_res_t      w_bb_vec;
    sat_res_t      w_ab;
    sat_res_t      w_ba_off;

    assign w_a_gnd = is_gnd(int'(r_node_a), SIZE);
    assign w_b_gnd = is_gnd(int'(r_node_b), SIZE);
    // a==b (including both ground) makes the whole stamp a no-op.
    assign w_same  = (r_node_a == r_node_b);

    // Ground indices are steered to row 0 so array reads stay in range; the
    // result is never written back in that case.
    assign w_ia = w_a_gnd ? '0 : r_node_a;
    assign w_ib = w_b_gnd ? '0 : r_node_b;

    assign w_aa     = sat_add(64'(r_work_a[w_ia][w_ia]),  64'(r_g), W);
    assign w_ba     = sat_add(64'(r_work_b[w_ia]),        64'(r_i), W);
    assign w_bb     = sat_add(64'(r_work_a[w_ib][w_ib]),  64'(r_g), W);
    assign w_bb_vec = sat_add(64'(r_work_b[w_ib]),       -64'(r_i), W);
    assign w_ab     = sat_add(64'(r_work_a[w_ia][w_ib]), -64'(r_g), W);
    assign w_ba_off = sat_add(64'(r_work_a[w_ib][w_ia]), -64'(r_g), W);

    always_comb begin
        w_diag_zero = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            if (r_work_a[k][k] == '0) w_diag_zero = 1'b1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within a cycle.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state          <= ST_IDLE;
            stamp_ready      <= 1'b1;
            matrix_valid     <= 1'b0;
            matrix_saturated <= 1'b0;
            diag_zero        <= 1'b0;
            r_sticky         <= 1'b0;
            r_node_a         <= '0;
            r_node_b         <= '0;
            r_g              <= '0;
            r_i              <= '0;
            r_last           <= 1'b0;
            // NOTE: the register arrays are reset explicitly because a reset
            // mid-frame must leave both the outputs and the accumulators at zero.
            for (int r = 0; r < SIZE; r++) begin
                b[r]        <= '0;
                r_work_b[r] <= '0;
                for (int c = 0; c < SIZE; c++) begin
                    A[r][c]        <= '0;
                    r_work_a[r][c] <= '0;
                end
            end
        end else begin
            matrix_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (stamp_valid && stamp_ready) begin
                        r_node_a    <= stamp_node_a;
                        r_node_b    <= stamp_node_b;
                        r_g         <= stamp_g;
                        r_i         <= stamp_i;
                        r_last      <= stamp_last;
                        stamp_ready <= 1'b0;
                        r_state     <= ST_ADD_A;
                        if (stamp_first) begin
                            r_sticky <= 1'b0;
                            for (int r = 0; r < SIZE; r++) begin
                                r_work_b[r] <= '0;
                                for (int c = 0; c < SIZE; c++) r_work_a[r][c] <= '0;
                            end
                        end
                    end
                end
                ST_ADD_A: begin
                    if (!w_a_gnd && !w_same) begin
                        r_work_a[w_ia][w_ia] <= w_aa.value[W-1:0];
                        r_work_b[w_ia]       <= w_ba.value[W-1:0];
                        r_sticky             <= r_sticky | w_aa.sat | w_ba.sat;
                    end
                    r_state <= ST_ADD_B;
                end
                ST_ADD_B: begin
                    if (!w_b_gnd && !w_same) begin
                        r_work_a[w_ib][w_ib] <= w_bb.value[W-1:0];
                        r_work_b[w_ib]       <= w_bb_vec.value[W-1:0];
                        r_sticky             <= r_sticky | w_bb.sat | w_bb_vec.sat;
                    end
                    r_state <= ST_OFFDIAG;
                end
                ST_OFFDIAG: begin
                    if (!w_a_gnd && !w_b_gnd && !w_same) begin
                        r_work_a[w_ia][w_ib] <= w_ab.value[W-1:0];
                        r_work_a[w_ib][w_ia] <= w_ba_off.value[W-1:0];
                        r_sticky             <= r_sticky | w_ab.sat | w_ba_off.sat;
                    end
                    if (r_last) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_state     <= ST_IDLE;
                        stamp_ready <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    A                <= r_work_a;
                    b                <= r_work_b;
                    matrix_saturated <= r_sticky;
                    diag_zero        <= w_diag_zero;
                    matrix_valid     <= 1'b1;
                    stamp_ready      <= 1'b1;
                    r_state          <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    stamp_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mna_stamper.sv
// -----------------------------------------------------------------------------
// tb_mna_stamper
// Self-checking bench for mna_stamper (SIZE=3, W=24). A behavioural nodal
// model (plain integer arrays, clamp-on-add) predicts every committed matrix,
// vector and flag, plus the handshake timing of each stamp.
// -----------------------------------------------------------------------------
module tb_mna_stamper;

    localparam int     SIZE = 3;
    localparam int     W    = 24;
    localparam int     NW   = 2;
    localparam int     GND  = 3;
    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;

    logic                clk;
    logic                I_RST;
    logic                stamp_valid;
    logic                stamp_ready;
    logic                stamp_first;
    logic                stamp_last;
    logic [NW-1:0]       stamp_node_a;
    logic [NW-1:0]       stamp_node_b;
    logic signed [W-1:0] stamp_g;
    logic signed [W-1:0] stamp_i;
    logic signed [W-1:0] A [SIZE][SIZE];
    logic signed [W-1:0] b [SIZE];
    logic                matrix_valid;
    logic                matrix_saturated;
    logic                diag_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: working accumulators and committed outputs.
    longint m_work_a [SIZE][SIZE];
    longint m_work_b [SIZE];
    longint m_A      [SIZE][SIZE];
    longint m_b      [SIZE];
    bit     m_sticky;
    bit     m_sat;
    bit     m_dz;

    mna_stamper #(.SIZE(3), .PRECISION(16), .POINT(8)) dut (
        .clk              (clk),
        .I_RST            (I_RST),
        .stamp_valid      (stamp_valid),
        .stamp_ready      (stamp_ready),
        .stamp_first      (stamp_first),
        .stamp_last       (stamp_last),
        .stamp_node_a     (stamp_node_a),
        .stamp_node_b     (stamp_node_b),
        .stamp_g          (stamp_g),
        .stamp_i          (stamp_i),
        .A                (A),
        .b                (b),
        .matrix_valid     (matrix_valid),
        .matrix_saturated (matrix_saturated),
        .diag_zero        (diag_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint acc(longint x, longint y);
        longint s;
        s = x + y;
        if (s > MAXV) begin
            m_sticky = 1'b1;
            return MAXV;
        end
        if (s < MINV) begin
            m_sticky = 1'b1;
            return MINV;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < SIZE; r++) begin
            m_work_b[r] = 0;
            m_b[r]      = 0;
            for (int c = 0; c < SIZE; c++) begin
                m_work_a[r][c] = 0;
                m_A[r][c]      = 0;
            end
        end
        m_sticky = 1'b0;
        m_sat    = 1'b0;
        m_dz     = 1'b0;
    endtask

    // Nodal stamp: g on both diagonals, -g on the mutual entries, i into a, out of b.
    task automatic model_stamp(bit first, int na, int nb, longint g, longint i);
        if (first) begin
            for (int r = 0; r < SIZE; r++) begin
                m_work_b[r] = 0;
                for (int c = 0; c < SIZE; c++) m_work_a[r][c] = 0;
            end
            m_sticky = 1'b0;
        end
        if (na != nb) begin
            if (na < SIZE) begin
                m_work_a[na][na] = acc(m_work_a[na][na], g);
                m_work_b[na]     = acc(m_work_b[na], i);
            end
            if (nb < SIZE) begin
                m_work_a[nb][nb] = acc(m_work_a[nb][nb], g);
                m_work_b[nb]     = acc(m_work_b[nb], -i);
            end
            if (na < SIZE && nb < SIZE) begin
                m_work_a[na][nb] = acc(m_work_a[na][nb], -g);
                m_work_a[nb][na] = acc(m_work_a[nb][na], -g);
            end
        end
    endtask

    task automatic model_commit();
        m_dz = 1'b0;
        for (int r = 0; r < SIZE; r++) begin
            m_b[r] = m_work_b[r];
            for (int c = 0; c < SIZE; c++) m_A[r][c] = m_work_a[r][c];
            if (m_work_a[r][r] == 0) m_dz = 1'b1;
        end
        m_sat = m_sticky;
    endtask

    task automatic check_outputs(input string tag);
        for (int r = 0; r < SIZE; r++) begin
            check($sformatf("%s b[%0d]", tag, r), 64'(b[r]), 64'(m_b[r]));
            for (int c = 0; c < SIZE; c++)
                check($sformatf("%s A[%0d][%0d]", tag, r, c), 64'(A[r][c]), 64'(m_A[r][c]));
        end
        check({tag, " saturated"}, 64'(matrix_saturated), 64'(m_sat));
        check({tag, " diag_zero"}, 64'(diag_zero), 64'(m_dz));
    endtask

    // Called at a negedge; returns at a negedge. keep_valid leaves stamp_valid
    // asserted through the busy window of a non-last stamp (backpressure test).
    task automatic send(bit first, bit last, int na, int nb, longint g, longint i,
                        bit keep_valid);
        int   budget;
        logic exp_ready;
        budget = 0;
        while (!stamp_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!stamp_ready) begin
            check("ready_timeout", 64'(stamp_ready), 64'd1);
            return;
        end
        stamp_valid  = 1'b1;
        stamp_first  = first;
        stamp_last   = last;
        stamp_node_a = NW'(na);
        stamp_node_b = NW'(nb);
        stamp_g      = g[W-1:0];
        stamp_i      = i[W-1:0];
        @(posedge clk);
        model_stamp(first, na, nb, g, i);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0 && (!keep_valid || last)) stamp_valid = 1'b0;
            exp_ready = (k < 3) ? 1'b0 : !last;
            check($sformatf("ready_after_accept+%0d", k), 64'(stamp_ready), 64'(exp_ready));
            check($sformatf("no_early_pulse+%0d", k), 64'(matrix_valid), 64'd0);
        end
        check_outputs("hold");
        if (last) begin
            @(negedge clk);
            model_commit();
            check("commit_pulse", 64'(matrix_valid), 64'd1);
            check("commit_ready", 64'(stamp_ready), 64'd1);
            check_outputs("commit");
            @(negedge clk);
            check("pulse_one_cycle", 64'(matrix_valid), 64'd0);
        end
    endtask

    initial begin
        int     n_stamps;
        bit     first;
        int     na;
        int     nb;
        longint g;
        longint i;

        I_RST        = 1'b1;
        stamp_valid  = 1'b0;
        stamp_first  = 1'b0;
        stamp_last   = 1'b0;
        stamp_node_a = '0;
        stamp_node_b = '0;
        stamp_g      = '0;
        stamp_i      = '0;
        model_reset();

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        I_RST = 1'b0;
        check("reset_ready", 64'(stamp_ready), 64'd1);
        check("reset_valid", 64'(matrix_valid), 64'd0);
        check_outputs("reset");

        // Voltage-divider frame.
        send(1, 0, 0, GND, 100, 500, 0);
        send(0, 0, 0, 1,   100, 0,   0);
        send(0, 1, 1, GND, 100, 0,   0);
        check("div A00", 64'(A[0][0]), 64'sd200);
        check("div A01", 64'(A[0][1]), -64'sd100);
        check("div A10", 64'(A[1][0]), -64'sd100);
        check("div A11", 64'(A[1][1]), 64'sd200);
        check("div b0",  64'(b[0]),    64'sd500);
        check("div diag_zero", 64'(diag_zero), 64'd1);

        // Backpressure: valid held high across a three-stamp frame.
        send(1, 0, 0, 1,   256, 40,  1);
        send(0, 0, 1, 2,   128, -20, 1);
        send(0, 1, 2, GND, 64,  10,  1);

        // Saturation of a diagonal entry.
        send(1, 0, 0, GND, 64'h7FFFFF, 0, 0);
        send(0, 1, 0, GND, 64'h7FFFFF, 0, 0);
        check("sat A00", 64'(A[0][0]), 64'sh7FFFFF);
        check("sat flag", 64'(matrix_saturated), 64'd1);

        // New frame after a commit: outputs hold until its own commit.
        send(1, 0, 2, 1, 300, 30, 0);
        send(0, 1, 0, GND, 50, -5, 0);
        check("newframe sat clear", 64'(matrix_saturated), 64'd0);

        // Self-loop stamp: committed A/b unchanged.
        send(0, 1, 1, 1, 100, 50, 0);

        // Reset during ADD_B of a last stamp.
        stamp_valid  = 1'b1;
        stamp_first  = 1'b1;
        stamp_last   = 1'b1;
        stamp_node_a = 2'd0;
        stamp_node_b = 2'd1;
        stamp_g      = 24'd300;
        stamp_i      = 24'd7;
        @(posedge clk);
        @(negedge clk);
        stamp_valid = 1'b0;
        @(negedge clk);
        I_RST = 1'b1;
        @(negedge clk);
        I_RST = 1'b0;
        model_reset();
        check("midreset ready", 64'(stamp_ready), 64'd1);
        check("midreset valid", 64'(matrix_valid), 64'd0);
        check_outputs("midreset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("midreset no_pulse+%0d", k), 64'(matrix_valid), 64'd0);
        end

        // Randomized frames against the model.
        for (int f = 0; f < 15; f++) begin
            n_stamps = int'($urandom_range(1, 4));
            for (int s = 0; s < n_stamps; s++) begin
                first = (s == 0) && ($urandom_range(0, 3) != 0);
                na    = int'($urandom_range(0, 3));
                nb    = int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) begin
                    g = longint'($urandom_range(0, 16777215)) - 64'sd8388608;
                    i = longint'($urandom_range(0, 16777215)) - 64'sd8388608;
                end else begin
                    g = longint'($urandom_range(0, 2000)) - 64'sd1000;
                    i = longint'($urandom_range(0, 2000)) - 64'sd1000;
                end
                send(first, s == n_stamps - 1, na, nb, g, i,
                     (s != n_stamps - 1) && ($urandom_range(0, 1) == 1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
